// File: rtl/ccu_pack_arb.sv
// ---------------------------------------------------------------------------
// ccu_pack_arb -- multi-channel CCU packetiser for the SPI return path.
//
// NUM_CH producers request the link. A round-robin arbiter picks one, its
// payload is buffered in a byte FIFO, then header + payload (+ checksum) are
// presented on txd_data one byte per rxd_flag pulse.
//
// Optional feature macro: CCU_PACK_CHECKSUM_EN
//   defined   -> one trailing byte = XOR of header bytes after SYNC and all
//                payload bytes.
//   undefined -> packet ends after the last payload byte.
//
// Ports
//   clk, rstn   clock, synchronous active-low reset
//   txd_data    byte offered to the SPI slave (0 when idle/collecting)
//   rxd_flag    1-cycle pulse: current byte consumed, advance
//   ch_req      per-channel request, held until grant drops
//   ch_gnt      one-hot grant, high while the granted channel streams payload
//   ch_valid    payload strobes (only the granted channel is honoured)
//   ch_data     payload bytes, channel c at [c*8 +: 8]
//   ch_id       16 b packet id per channel, sampled at grant
//   ch_len      LEN_W b payload length per channel, sampled at grant
//   ch_type     8 b packet type per channel, sampled at grant
//   busy        high from grant until the last byte is consumed
//   len_err     1-cycle pulse: request rejected because len > DEPTH
// ---------------------------------------------------------------------------
module ccu_pack_arb #(
  parameter int         NUM_CH    = 2,
  parameter int         DEPTH     = 1024,
  parameter int         LEN_W     = 13,
  parameter logic [7:0] SYNC_BYTE = 8'h5A
) (
  input  logic                    clk,
  input  logic                    rstn,
  output logic [7:0]              txd_data,
  input  logic                    rxd_flag,
  input  logic [NUM_CH-1:0]       ch_req,
  output logic [NUM_CH-1:0]       ch_gnt,
  input  logic [NUM_CH-1:0]       ch_valid,
  input  logic [NUM_CH*8-1:0]     ch_data,
  input  logic [NUM_CH*16-1:0]    ch_id,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  input  logic [NUM_CH*8-1:0]     ch_type,
  output logic                    busy,
  output logic                    len_err
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_HDR, S_DATA, S_CSUM} state_t;

  state_t           state;
  logic [CW-1:0]    rr_ptr, win, gch;
  logic             win_vld;
  logic [15:0]      gid;
  logic [LEN_W-1:0] glen;
  logic [7:0]       gtype;
  logic [LEN_W-1:0] wr_cnt, rd_cnt;
  logic [2:0]       hidx;
  logic [7:0]       mem [DEPTH];

  logic [15:0]      sel_id, glen16;
  logic [LEN_W-1:0] sel_len;
  logic [7:0]       sel_type, cur_data, hdr_nxt, rd_nxt;
  logic [AW-1:0]    rd_nxt_addr;
  logic             cur_vld, len_bad, last_wr, last_rd, wr_en;

`ifdef CCU_PACK_CHECKSUM_EN
  logic [7:0]       csum;
  logic [15:0]      sel_len16;
  assign sel_len16 = 16'(sel_len);
`endif

  // Round-robin: scan from farthest to nearest offset after rr_ptr so the
  // nearest requester overwrites and wins.
  always_comb begin
    win_vld = 1'b0;
    win     = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (ch_req[CW'((int'(rr_ptr) + i) % NUM_CH)]) begin
        win_vld = 1'b1;
        win     = CW'((int'(rr_ptr) + i) % NUM_CH);
      end
    end
  end

  assign sel_id   = ch_id[int'(win)*16 +: 16];
  assign sel_len  = ch_len[int'(win)*LEN_W +: LEN_W];
  assign sel_type = ch_type[int'(win)*8 +: 8];
  assign len_bad  = 32'(sel_len) > 32'(DEPTH);

  assign cur_vld  = ch_valid[gch];
  assign cur_data = ch_data[int'(gch)*8 +: 8];
  assign glen16   = 16'(glen);
  assign last_wr  = (wr_cnt == glen - LEN_W'(1));
  assign last_rd  = (rd_cnt == glen - LEN_W'(1));
  assign wr_en    = rstn && (state == S_COLLECT) && (glen != '0) && cur_vld;

  // FIFO head after the pending pop (entering DATA the head is entry 0).
  assign rd_nxt_addr = (state == S_DATA) ? rd_cnt[AW-1:0] + AW'(1) : '0;
  assign rd_nxt      = mem[rd_nxt_addr];

  // Header byte that follows index hidx.
  always_comb begin
    hdr_nxt = SYNC_BYTE;
    case (hidx)
      3'd0:    hdr_nxt = gid[7:0];
      3'd1:    hdr_nxt = gid[15:8];
      3'd2:    hdr_nxt = glen16[7:0];
      3'd3:    hdr_nxt = glen16[15:8];
      3'd4:    hdr_nxt = gtype;
      3'd5:    hdr_nxt = {5'b0, 3'(gch)};
      default: hdr_nxt = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk)
    if (wr_en) mem[wr_cnt[AW-1:0]] <= cur_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= S_IDLE;
      rr_ptr   <= CW'(NUM_CH - 1);
      gch      <= '0;
      gid      <= '0;
      glen     <= '0;
      gtype    <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      hidx     <= '0;
      txd_data <= '0;
      ch_gnt   <= '0;
      busy     <= 1'b0;
      len_err  <= 1'b0;
`ifdef CCU_PACK_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      len_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win_vld) begin
            // Rejected or not, the winner takes lowest priority next round.
            rr_ptr <= win;
            if (len_bad) begin
              len_err <= 1'b1;
            end else begin
              ch_gnt <= NUM_CH'(1) << win;
              busy   <= 1'b1;
              gch    <= win;
              gid    <= sel_id;
              glen   <= sel_len;
              gtype  <= sel_type;
              wr_cnt <= '0;
              rd_cnt <= '0;
              hidx   <= '0;
              state  <= S_COLLECT;
`ifdef CCU_PACK_CHECKSUM_EN
              csum   <= sel_id[7:0] ^ sel_id[15:8] ^ sel_len16[7:0] ^
                        sel_len16[15:8] ^ sel_type ^ {5'b0, 3'(win)};
`endif
            end
          end
        end

        S_COLLECT: begin
          if (glen == '0) begin
            ch_gnt   <= '0;
            txd_data <= SYNC_BYTE;
            state    <= S_HDR;
          end else if (cur_vld) begin
            wr_cnt <= wr_cnt + LEN_W'(1);
`ifdef CCU_PACK_CHECKSUM_EN
            csum   <= csum ^ cur_data;
`endif
            if (last_wr) begin
              ch_gnt   <= '0;
              txd_data <= SYNC_BYTE;
              state    <= S_HDR;
            end
          end
        end

        S_HDR: begin
          if (rxd_flag) begin
            if (hidx == 3'd6) begin
              hidx <= '0;
              if (glen != '0) begin
                txd_data <= rd_nxt;
                state    <= S_DATA;
              end else begin
`ifdef CCU_PACK_CHECKSUM_EN
                txd_data <= csum;
                state    <= S_CSUM;
`else
                txd_data <= '0;
                busy     <= 1'b0;
                state    <= S_IDLE;
`endif
              end
            end else begin
              hidx     <= hidx + 3'd1;
              txd_data <= hdr_nxt;
            end
          end
        end

        S_DATA: begin
          if (rxd_flag) begin
            rd_cnt <= rd_cnt + LEN_W'(1);
            if (last_rd) begin
`ifdef CCU_PACK_CHECKSUM_EN
              txd_data <= csum;
              state    <= S_CSUM;
`else
              txd_data <= '0;
              busy     <= 1'b0;
              state    <= S_IDLE;
`endif
            end else begin
              txd_data <= rd_nxt;
            end
          end
        end

`ifdef CCU_PACK_CHECKSUM_EN
        S_CSUM: begin
          if (rxd_flag) begin
            txd_data <= '0;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end
        end
`endif

        default: state <= S_IDLE;
      endcase
    end
  end

  // Popping beyond what was collected would mean the length bookkeeping broke.
  always_ff @(posedge clk)
    if (rstn && state == S_DATA && rxd_flag)
      assert (rd_cnt < wr_cnt);

endmodule

// File: tb/tb_ccu_pack_arb.sv
// ---------------------------------------------------------------------------
// tb_ccu_pack_arb -- directed + randomized bench for ccu_pack_arb.
// A behavioural model builds each packet's byte list from id/len/type/ch and
// the payload, and tracks the round-robin pointer as a plain integer.
// ---------------------------------------------------------------------------
module tb_ccu_pack_arb;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 1024;
  localparam int LEN_W  = 13;
  localparam int DW     = NUM_CH * 8;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [7:0]              txd_data;
  logic                    rxd_flag;
  logic [NUM_CH-1:0]       ch_req, ch_gnt, ch_valid;
  logic [NUM_CH*8-1:0]     ch_data, ch_type;
  logic [NUM_CH*16-1:0]    ch_id;
  logic [NUM_CH*LEN_W-1:0] ch_len;
  logic                    busy, len_err;

  always #5 clk = ~clk;

  ccu_pack_arb #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn), .txd_data(txd_data), .rxd_flag(rxd_flag),
    .ch_req(ch_req), .ch_gnt(ch_gnt), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_id(ch_id), .ch_len(ch_len), .ch_type(ch_type), .busy(busy), .len_err(len_err)
  );

  int          n_chk = 0;
  int          n_fail = 0;
  int          rr;
  logic [15:0] p_id   [NUM_CH];
  int          p_len  [NUM_CH];
  logic [7:0]  p_type [NUM_CH];
  logic [7:0]  p_data [NUM_CH][64];
  logic [7:0]  expq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester strictly after ptr, wrapping.
  function automatic int pick(input logic [NUM_CH-1:0] req, input int ptr);
    for (int i = 1; i <= NUM_CH; i++)
      if (req[(ptr + i) % NUM_CH]) return (ptr + i) % NUM_CH;
    return -1;
  endfunction

  task automatic set_pkt(input int c, input logic [15:0] id, input int len, input logic [7:0] ty);
    p_id[c] = id; p_len[c] = len; p_type[c] = ty;
    for (int k = 0; k < 64; k++) p_data[c][k] = 8'($urandom);
    ch_id[c*16 +: 16]       = id;
    ch_len[c*LEN_W +: LEN_W] = LEN_W'(len);
    ch_type[c*8 +: 8]       = ty;
  endtask

  task automatic build_exp(input int c);
    logic [7:0] x;
    expq = {};
    expq.push_back(8'h5A);
    expq.push_back(p_id[c][7:0]);
    expq.push_back(p_id[c][15:8]);
    expq.push_back(8'(p_len[c] % 256));
    expq.push_back(8'(p_len[c] / 256));
    expq.push_back(p_type[c]);
    expq.push_back(8'(c));
    for (int k = 0; k < p_len[c]; k++) expq.push_back(p_data[c][k]);
`ifdef CCU_PACK_CHECKSUM_EN
    x = 8'h00;
    for (int j = 1; j < expq.size(); j++) x = x ^ expq[j];
    expq.push_back(x);
`endif
  endtask

  // Wait for the grant, stream the payload with random gaps and noise.
  task automatic serve_collect(output int c);
    int w, k, it;
    w = 0; k = 0; it = 0;
    c = pick(ch_req, rr);
    do begin @(negedge clk); w++; end while (ch_gnt == '0 && w < 20);
    chk("gnt_latency", w, 1);
    if (c < 0) return;
    chk("gnt_onehot", 32'(ch_gnt), 32'(1) << c);
    chk("busy_at_gnt", 32'(busy), 1);
    rr = c;
    if (p_len[c] == 0) begin
      ch_data = DW'($urandom); ch_valid[c] = 1'b1;
      @(negedge clk);
      ch_valid = '0;
      chk("gnt_len0_drop", 32'(ch_gnt), 0);
    end else begin
      while (k < p_len[c] && it < 400) begin
        ch_data  = DW'($urandom);
        ch_valid = NUM_CH'($urandom);
        rxd_flag = 1'($urandom);
        if (ch_valid[c]) begin ch_data[c*8 +: 8] = p_data[c][k]; k++; end
        it++;
        @(negedge clk);
        if (k < p_len[c]) begin
          chk("gnt_hold", 32'(ch_gnt), 32'(1) << c);
          chk("txd_collect", 32'(txd_data), 0);
        end else begin
          chk("gnt_drop", 32'(ch_gnt), 0);
        end
      end
    end
    ch_valid  = '0;
    rxd_flag  = 1'b0;
    ch_req[c] = 1'b0;
  endtask

  // Consume up to nstop bytes, checking each against the model.
  task automatic drain(input int c, input int nstop);
    build_exp(c);
    for (int j = 0; j < expq.size() && j < nstop; j++) begin
      repeat ($urandom_range(0, 1)) @(negedge clk);
      chk($sformatf("ch%0d_byte%0d", c, j), 32'(txd_data), 32'(expq[j]));
      if (j == 0) chk("busy_hdr", 32'(busy), 1);
      rxd_flag = 1'b1;
      @(negedge clk);
      rxd_flag = 1'b0;
    end
    if (nstop >= expq.size()) begin
      chk("busy_end", 32'(busy), 0);
      chk("txd_end", 32'(txd_data), 0);
    end
  endtask

  initial begin
    int c, g;
    rstn = 1'b0; ch_req = '0; ch_valid = '0; ch_data = '0; ch_id = '0;
    ch_len = '0; ch_type = '0; rxd_flag = 1'b0; rr = NUM_CH - 1;
    repeat (3) @(negedge clk);
    chk("rst_txd", 32'(txd_data), 0);
    chk("rst_gnt", 32'(ch_gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_len_err", 32'(len_err), 0);
    rstn = 1'b1;

    // Reference packet on ch0.
    set_pkt(0, 16'h1234, 3, 8'h07);
    p_data[0][0] = 8'h11; p_data[0][1] = 8'h22; p_data[0][2] = 8'h33;
    ch_req[0] = 1'b1;
    serve_collect(c); drain(c, 100);

    // ch1 alone moves the pointer to 1, then contention twice.
    set_pkt(1, 16'($urandom), $urandom_range(1, 8), 8'($urandom));
    ch_req[1] = 1'b1;
    serve_collect(c); drain(c, 100);
    repeat (2) begin
      for (int i = 0; i < NUM_CH; i++)
        set_pkt(i, 16'($urandom), $urandom_range(1, 8), 8'($urandom));
      ch_req = '1;
      serve_collect(c); drain(c, 100);
      serve_collect(c); drain(c, 100);
    end

    // Oversized request: rejected, pointer still moves past ch1.
    set_pkt(0, 16'($urandom), $urandom_range(1, 8), 8'($urandom));
    ch_req[0] = 1'b1;
    serve_collect(c); drain(c, 100);
    set_pkt(1, 16'hBEEF, DEPTH + 1, 8'h55);
    ch_req[1] = 1'b1;
    @(negedge clk);
    chk("len_err_pulse", 32'(len_err), 1);
    chk("len_err_no_gnt", 32'(ch_gnt), 0);
    chk("len_err_txd", 32'(txd_data), 0);
    chk("len_err_busy", 32'(busy), 0);
    ch_req[1] = 1'b0;
    rr = 1;
    @(negedge clk);
    chk("len_err_clear", 32'(len_err), 0);
    chk("len_err_txd2", 32'(txd_data), 0);
    for (int i = 0; i < NUM_CH; i++)
      set_pkt(i, 16'($urandom), $urandom_range(1, 8), 8'($urandom));
    ch_req = '1;
    serve_collect(c); drain(c, 100);
    serve_collect(c); drain(c, 100);

    // Zero-length packet on ch1.
    set_pkt(1, 16'hA5C3, 0, 8'h3C);
    ch_req[1] = 1'b1;
    serve_collect(c); drain(c, 100);

    // Randomized mixes, lengths 0..12.
    repeat (25) begin
      for (int i = 0; i < NUM_CH; i++)
        set_pkt(i, 16'($urandom), $urandom_range(0, 12), 8'($urandom));
      ch_req = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      g = 0;
      while (ch_req != '0 && g < 2 * NUM_CH) begin
        serve_collect(c); drain(c, 100);
        g++;
      end
    end

    // Reset after 2 of 5 payload bytes.
    set_pkt(0, 16'($urandom), 5, 8'($urandom));
    ch_req[0] = 1'b1;
    serve_collect(c); drain(c, 9);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_txd", 32'(txd_data), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_gnt", 32'(ch_gnt), 0);
    rstn = 1'b1;
    rr = NUM_CH - 1;
    set_pkt(0, 16'($urandom), 2, 8'($urandom));
    ch_req[0] = 1'b1;
    serve_collect(c); drain(c, 100);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
